// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address generator bus; master = pc_gen, slave = CTRL/ID/imem side
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) ();
  logic [STALL_W-1:0] stall;
  logic               flush_i;
  logic [ADDR_W-1:0]  new_pc_i;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic               if_ack_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               branch_pending_o;
  logic               misalign_o;
  modport master (
    input  stall, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, if_ack_i,
    output pc, ce, branch_pending_o, misalign_o
  );
  modport slave (
    output stall, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, if_ack_i,
    input  pc, ce, branch_pending_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC with flush/branch redirect, pending-branch buffer and imem ack handshake; ports clk, rst, bus (pc_gen_if.master); PC_ALIGN_CHECK_EN enables misalign_o
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                STALL_W    = 6
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n, tgt, tgt_n;
  logic              pend_n, adv, unused_stall;
  assign unused_stall = ^bus.stall;
  assign adv = bus.ce & ~bus.stall[0] & bus.if_ack_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= BOOT;
      bus.pc               <= RESET_VEC;
      bus.ce               <= 1'b0;
      bus.branch_pending_o <= 1'b0;
      tgt                  <= '0;
    end else begin
      state                <= state_n;
      bus.pc               <= pc_n;
      bus.ce               <= 1'b1;
      bus.branch_pending_o <= pend_n;
      tgt                  <= tgt_n;
    end
  end
  always_comb begin
    state_n = RUN;
    pc_n    = bus.pc;
    pend_n  = bus.branch_pending_o;
    tgt_n   = tgt;
    if (state == RUN) begin
      if (bus.flush_i) begin
        pc_n   = bus.new_pc_i;
        pend_n = 1'b0;
      end else if (adv) begin
        pc_n   = bus.branch_flag_i ? bus.branch_target_address_i :
                 bus.branch_pending_o ? tgt : bus.pc + ADDR_W'(INST_BYTES);
        pend_n = 1'b0;
      end else if (bus.branch_flag_i) begin
        pend_n = 1'b1;
        tgt_n  = bus.branch_target_address_i;
      end
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  // masking with INST_BYTES-1 makes the flag constant 0 when INST_BYTES=1
  always_ff @(posedge clk)
    bus.misalign_o <= rst ? 1'b0 : bus.ce && ((bus.pc & ADDR_W'(INST_BYTES - 1)) != '0);
`else
  assign bus.misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen
module tb_pc_gen;
  localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();
  pc_gen #(.ADDR_W(32), .RESET_VEC(RV), .INST_BYTES(4), .STALL_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic st, input logic fl,
                      input logic [31:0] npc, input logic br, input logic [31:0] bta,
                      input logic ack, input logic [31:0] epc, input logic ece,
                      input logic epend, input logic emis);
    exp_t e;
    rst = r;
    bus.stall = {5'b10101, st};
    bus.flush_i = fl;
    bus.new_pc_i = npc;
    bus.branch_flag_i = br;
    bus.branch_target_address_i = bta;
    bus.if_ack_i = ack;
    sb.push_back('{pc: epc, ce: ece, pend: epend, mis: emis & ALN});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"}, bus.pc, e.pc);
    check({tag, ".ce"}, {31'b0, bus.ce}, {31'b0, e.ce});
    check({tag, ".pend"}, {31'b0, bus.branch_pending_o}, {31'b0, e.pend});
    check({tag, ".mis"}, {31'b0, bus.misalign_o}, {31'b0, e.mis});
  endtask
  initial begin
    @(negedge clk);
    //    tag      rst st fl npc          br bta          ack  pc           ce pend mis
    step("rst0",   1, 0, 0, 32'h0,       0, 32'h0,       1,   RV,          0, 0, 0);
    step("rst1",   1, 0, 0, 32'h0,       0, 32'h0,       1,   RV,          0, 0, 0);
    step("boot",   0, 0, 1, 32'h44,      1, 32'h88,      1,   RV,          1, 0, 0);
    step("seq1",   0, 0, 0, 32'h0,       0, 32'h0,       1,   RV + 4,      1, 0, 0);
    step("seq2",   0, 0, 0, 32'h0,       0, 32'h0,       1,   RV + 8,      1, 0, 0);
    step("stbr",   0, 1, 0, 32'h0,       1, 32'h100,     1,   RV + 8,      1, 1, 0);
    step("stapp",  0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h100,     1, 0, 0);
    step("seq3",   0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h104,     1, 0, 0);
    step("fl10",   0, 0, 1, 32'h10,      0, 32'h0,       1,   32'h10,      1, 0, 0);
    step("nack0",  0, 0, 0, 32'h0,       0, 32'h0,       0,   32'h10,      1, 0, 0);
    step("nack1",  0, 0, 0, 32'h0,       0, 32'h0,       0,   32'h10,      1, 0, 0);
    step("nack2",  0, 0, 0, 32'h0,       0, 32'h0,       0,   32'h10,      1, 0, 0);
    step("ackok",  0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h14,      1, 0, 0);
    step("flbr",   0, 1, 1, 32'h20,      1, 32'h400,     0,   32'h20,      1, 0, 0);
    step("flhold", 0, 1, 0, 32'h0,       0, 32'h0,       1,   32'h20,      1, 0, 0);
    step("flnext", 0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h24,      1, 0, 0);
    step("ovr1",   0, 1, 0, 32'h0,       1, 32'h200,     1,   32'h24,      1, 1, 0);
    step("ovr2",   0, 0, 0, 32'h0,       1, 32'h300,     0,   32'h24,      1, 1, 0);
    step("ovrhld", 0, 0, 0, 32'h0,       0, 32'h0,       0,   32'h24,      1, 1, 0);
    step("ovrapp", 0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h300,     1, 0, 0);
    step("advbr",  0, 0, 0, 32'h0,       1, 32'h500,     1,   32'h500,     1, 0, 0);
    step("flwrap", 0, 0, 1, 32'hFFFFFFFC,0, 32'h0,       0,   32'hFFFFFFFC,1, 0, 0);
    step("wrap",   0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h0,       1, 0, 0);
    step("wrap2",  0, 0, 0, 32'h0,       0, 32'h0,       1,   32'h4,       1, 0, 0);
    step("fl6",    0, 1, 1, 32'h6,       0, 32'h0,       0,   32'h6,       1, 0, 0);
    step("mis1",   0, 1, 0, 32'h0,       0, 32'h0,       0,   32'h6,       1, 0, 1);
    step("fl8",    0, 1, 1, 32'h8,       0, 32'h0,       0,   32'h8,       1, 0, 1);
    step("mis0",   0, 1, 0, 32'h0,       0, 32'h0,       0,   32'h8,       1, 0, 0);
    step("prst",   0, 1, 0, 32'h0,       1, 32'h600,     1,   32'h8,       1, 1, 0);
    step("rstmid", 1, 0, 1, 32'h700,     1, 32'h800,     1,   RV,          0, 0, 0);
    step("boot2",  0, 0, 0, 32'h0,       0, 32'h0,       1,   RV,          1, 0, 0);
    step("seq4",   0, 0, 0, 32'h0,       0, 32'h0,       1,   RV + 4,      1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
